// File: rtl/srio_dma_splitter.sv
// srio_dma_splitter: chops one AXI-Stream DMA transfer into a programmed number of
// fixed-length SRIO packets, with TLAST at each boundary and a per-packet TUSER header.
module srio_dma_splitter #(
  parameter int DATA_WIDTH  = 64,
  parameter int TUSER_WIDTH = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   AXIS_ACLK,
  input  logic                   AXIS_ARESETN,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_beats,
  input  logic [CNT_WIDTH-1:0]   cfg_num_pkts,
  input  logic [TUSER_WIDTH-1:0] cfg_tuser,
  input  logic [TUSER_WIDTH-1:0] cfg_tuser_last,
  input  logic [DATA_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  input  logic                   S_AXIS_TLAST,
  output logic                   S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  output logic                   M_AXIS_TLAST,
  output logic [TUSER_WIDTH-1:0] M_AXIS_TUSER,
  input  logic                   M_AXIS_TREADY,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [3:0]             status
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                 state_r, state_nxt_s;
  logic [LEN_WIDTH-1:0]   pkt_beats_r, beat_cnt_r;
  logic [CNT_WIDTH-1:0]   num_pkts_r, pkt_idx_r, pkt_count_r;
  logic [TUSER_WIDTH-1:0] tuser_r, tuser_last_r, m_user_r;
  logic [DATA_WIDTH-1:0]  m_data_r;
  logic                   m_valid_r, m_last_r, final_accepted_r, done_r;
  logic [3:0]             status_r;

  logic s_ready_s, busy_s, accept_s, out_hs_s, abort_s, start_s, cfg_bad_s;
  logic pkt_end_s, last_pkt_s, final_beat_s;

  // abort outranks start; start is only honoured while idle
  assign abort_s      = cfg_abort && (state_r != IDLE);
  assign start_s      = cfg_start && !cfg_abort && (state_r == IDLE);
  assign cfg_bad_s    = (cfg_pkt_beats == {LEN_WIDTH{1'b0}}) || (cfg_num_pkts == {CNT_WIDTH{1'b0}});
  assign out_hs_s     = m_valid_r && M_AXIS_TREADY;
  assign accept_s     = s_ready_s && S_AXIS_TVALID;
  assign pkt_end_s    = (beat_cnt_r == pkt_beats_r - LEN_WIDTH'(1));
  assign last_pkt_s   = (pkt_idx_r == num_pkts_r - CNT_WIDTH'(1));
  assign final_beat_s = pkt_end_s && last_pkt_s;

  // state register
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) state_r <= IDLE;
    else               state_r <= state_nxt_s;
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s && !cfg_bad_s) state_nxt_s = RUN;
        else                       state_nxt_s = IDLE;
      end
      RUN: begin
        if (abort_s)                                             state_nxt_s = IDLE;
        else if (accept_s && (final_beat_s || S_AXIS_TLAST))     state_nxt_s = FLUSH;
        else                                                     state_nxt_s = RUN;
      end
      FLUSH: begin
        if (abort_s || out_hs_s) state_nxt_s = IDLE;
        else                     state_nxt_s = FLUSH;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state-decoded outputs; input ready follows output ready combinationally
  always_comb begin
    s_ready_s = 1'b0;
    busy_s    = 1'b0;
    case (state_r)
      RUN: begin
        s_ready_s = (!m_valid_r || M_AXIS_TREADY) && !final_accepted_r;
        busy_s    = 1'b1;
      end
      FLUSH: begin
        s_ready_s = 1'b0;
        busy_s    = 1'b1;
      end
      IDLE: begin
        s_ready_s = 1'b0;
        busy_s    = 1'b0;
      end
      default: begin
        s_ready_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // job config, counters, output pipeline register and status flags
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      pkt_beats_r      <= {LEN_WIDTH{1'b0}};
      num_pkts_r       <= {CNT_WIDTH{1'b0}};
      tuser_r          <= {TUSER_WIDTH{1'b0}};
      tuser_last_r     <= {TUSER_WIDTH{1'b0}};
      beat_cnt_r       <= {LEN_WIDTH{1'b0}};
      pkt_idx_r        <= {CNT_WIDTH{1'b0}};
      pkt_count_r      <= {CNT_WIDTH{1'b0}};
      m_data_r         <= {DATA_WIDTH{1'b0}};
      m_user_r         <= {TUSER_WIDTH{1'b0}};
      m_valid_r        <= 1'b0;
      m_last_r         <= 1'b0;
      final_accepted_r <= 1'b0;
      done_r           <= 1'b0;
      status_r         <= 4'b0000;
    end else begin
      if (out_hs_s && m_last_r && (pkt_count_r != {CNT_WIDTH{1'b1}}))
        pkt_count_r <= pkt_count_r + CNT_WIDTH'(1);

      if (start_s) begin
        pkt_beats_r      <= cfg_pkt_beats;
        num_pkts_r       <= cfg_num_pkts;
        tuser_r          <= cfg_tuser;
        tuser_last_r     <= cfg_tuser_last;
        beat_cnt_r       <= {LEN_WIDTH{1'b0}};
        pkt_idx_r        <= {CNT_WIDTH{1'b0}};
        pkt_count_r      <= {CNT_WIDTH{1'b0}};
        final_accepted_r <= 1'b0;
        done_r           <= 1'b0;
        status_r         <= cfg_bad_s ? 4'b1000 : 4'b0000;
      end else if (abort_s) begin
        m_valid_r        <= 1'b0;
        final_accepted_r <= 1'b0;
        status_r[2]      <= 1'b1;
      end else begin
        if (out_hs_s) m_valid_r <= 1'b0;
        if (accept_s) begin
          m_valid_r <= 1'b1;
          m_data_r  <= S_AXIS_TDATA;
          m_last_r  <= pkt_end_s || S_AXIS_TLAST;
          m_user_r  <= last_pkt_s ? tuser_last_r : tuser_r;
          if (final_beat_s) begin
            final_accepted_r <= 1'b1;
            if (!S_AXIS_TLAST) status_r[1] <= 1'b1;
          end else if (S_AXIS_TLAST) begin
            status_r[0] <= 1'b1;
          end else if (pkt_end_s) begin
            beat_cnt_r <= {LEN_WIDTH{1'b0}};
            pkt_idx_r  <= pkt_idx_r + CNT_WIDTH'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r + LEN_WIDTH'(1);
          end
        end
        if ((state_r == FLUSH) && out_hs_s && (status_r == 4'b0000))
          done_r <= 1'b1;
      end
    end
  end

  assign S_AXIS_TREADY = s_ready_s;
  assign busy          = busy_s;
  assign M_AXIS_TDATA  = m_data_r;
  assign M_AXIS_TVALID = m_valid_r;
  assign M_AXIS_TLAST  = m_last_r;
  assign M_AXIS_TUSER  = m_user_r;
  assign done          = done_r;
  assign pkt_count     = pkt_count_r;
  assign status        = status_r;

endmodule

// File: tb/tb_srio_dma_splitter.sv
// Scoreboard bench for srio_dma_splitter: expected beats are queued as input is
// accepted and compared against every output handshake.
module tb_srio_dma_splitter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_start, cfg_abort;
  logic [7:0]  cfg_pkt_beats;
  logic [15:0] cfg_num_pkts;
  logic [31:0] cfg_tuser, cfg_tuser_last;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tuser;
  logic        busy, done;
  logic [15:0] pkt_count;
  logic [3:0]  status;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic [31:0] u;
  } beat_t;

  beat_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_n = 0;
  int          hs_first = 0;
  int          hs_last = 0;
  logic        rand_en = 1'b0;
  logic        prev_stall = 1'b0;
  beat_t       prev_b;

  srio_dma_splitter dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rstn),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_pkt_beats(cfg_pkt_beats), .cfg_num_pkts(cfg_num_pkts),
    .cfg_tuser(cfg_tuser), .cfg_tuser_last(cfg_tuser_last),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TUSER(m_tuser), .M_AXIS_TREADY(m_tready),
    .busy(busy), .done(done), .pkt_count(pkt_count), .status(status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_en) m_tready = 1'($urandom_range(0, 1));
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // output monitor: scoreboard compare on handshake, hold check while stalled
  always @(negedge clk) begin
    beat_t b;
    if (!rstn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && m_tvalid) begin
        check_val("hold_data", m_tdata, prev_b.d);
        check_val("hold_last", {63'd0, m_tlast}, {63'd0, prev_b.l});
        check_val("hold_user", {32'd0, m_tuser}, {32'd0, prev_b.u});
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          check_val("out_data", m_tdata, b.d);
          check_val("out_last", {63'd0, m_tlast}, {63'd0, b.l});
          check_val("out_user", {32'd0, m_tuser}, {32'd0, b.u});
        end
        if (hs_n == 0) hs_first = cyc;
        hs_last = cyc;
        hs_n++;
      end
      prev_stall <= m_tvalid && !m_tready;
      prev_b     <= '{d: m_tdata, l: m_tlast, u: m_tuser};
    end
  end

  task automatic start_job(input int p, input int n, input logic [31:0] u, input logic [31:0] ul);
    cfg_pkt_beats  = 8'(p);
    cfg_num_pkts   = 16'(n);
    cfg_tuser      = u;
    cfg_tuser_last = ul;
    cfg_start      = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    hs_n = 0;
  endtask

  // drive beat i of a job and queue its expected output once accepted
  task automatic send_beat(input int i, input int p, input int n, input logic [31:0] u,
                           input logic [31:0] ul, input logic l);
    int    wait_n = 0;
    beat_t e;
    s_tdata  = {$urandom, $urandom};
    s_tvalid = 1'b1;
    s_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      wait_n++;
      if (wait_n > 300) break;
    end
    if (wait_n > 300) begin
      check_val("accept_timeout", 64'd0, 64'd1);
      s_tvalid = 1'b0;
    end else begin
      e.d = s_tdata;
      e.l = ((i % p) == (p - 1)) || l;
      e.u = ((i / p) == (n - 1)) ? ul : u;
      exp_q.push_back(e);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic run_job(input int p, input int n, input int nb, input int tl_at,
                         input logic [31:0] u, input logic [31:0] ul);
    start_job(p, n, u, ul);
    check_val("busy_after_start", {63'd0, busy}, 64'd1);
    check_val("cnt_after_start", {48'd0, pkt_count}, 64'd0);
    for (int i = 0; i < nb; i++) send_beat(i, p, n, u, ul, i == tl_at);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 1000);
    check_val("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_end(input string tag, input logic d, input int cnt, input logic [3:0] st);
    check_val({tag, "_done"}, {63'd0, done}, {63'd0, d});
    check_val({tag, "_pkt_count"}, {48'd0, pkt_count}, 64'(cnt));
    check_val({tag, "_status"}, {60'd0, status}, {60'd0, st});
    check_val({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_pkt_beats = 8'd0; cfg_num_pkts = 16'd0; cfg_tuser = 32'd0; cfg_tuser_last = 32'd0;
    s_tdata = 64'd0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_mvalid", {63'd0, m_tvalid}, 64'd0);
    check_val("rst_mdata", m_tdata, 64'd0);
    check_val("rst_mlast", {63'd0, m_tlast}, 64'd0);
    check_val("rst_muser", {32'd0, m_tuser}, 64'd0);
    check_val("rst_sready", {63'd0, s_tready}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_cnt", {48'd0, pkt_count}, 64'd0);
    check_val("rst_status", {60'd0, status}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // clean job, output always ready: no gaps expected
    run_job(4, 3, 12, 11, 32'hA, 32'hB);
    wait_idle();
    check_end("clean", 1'b1, 3, 4'b0000);
    check_val("clean_hs_count", 64'(hs_n), 64'd12);
    check_val("clean_no_gaps", 64'(hs_last - hs_first), 64'd11);
    @(posedge clk); #1;

    // same job with random backpressure
    rand_en = 1'b1;
    run_job(4, 3, 12, 11, 32'hA, 32'hB);
    wait_idle();
    check_end("rand", 1'b1, 3, 4'b0000);
    check_val("rand_hs_count", 64'(hs_n), 64'd12);
    rand_en = 1'b0;
    @(posedge clk); #1;
    m_tready = 1'b1;

    // input ends early: packet 1 closes at beat 5
    run_job(4, 3, 6, 5, 32'hA, 32'hB);
    wait_idle();
    check_end("short", 1'b0, 2, 4'b0001);
    @(posedge clk); #1;

    // input too long: beat 4 must stay pending
    run_job(2, 2, 4, -1, 32'hA, 32'hB);
    s_tdata = 64'h4444; s_tvalid = 1'b1; s_tlast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("long_sready", {63'd0, s_tready}, 64'd0);
    end
    wait_idle();
    check_end("long", 1'b0, 2, 4'b0010);
    check_val("long_sready_idle", {63'd0, s_tready}, 64'd0);
    @(posedge clk); #1;
    s_tvalid = 1'b0;

    // abort during packet 1 with the output stalled
    run_job(4, 3, 5, -1, 32'hA, 32'hB);
    m_tready = 1'b0;
    @(posedge clk); #1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    check_val("abort_mvalid", {63'd0, m_tvalid}, 64'd0);
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    check_val("abort_sready", {63'd0, s_tready}, 64'd0);
    check_val("abort_status", {60'd0, status}, 64'd4);
    check_val("abort_done", {63'd0, done}, 64'd0);
    check_val("abort_cnt", {48'd0, pkt_count}, 64'd1);
    check_val("abort_dropped", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    m_tready = 1'b1;
    @(posedge clk); #1;
    run_job(4, 3, 12, 11, 32'hA, 32'hB);
    wait_idle();
    check_end("after_abort", 1'b1, 3, 4'b0000);
    @(posedge clk); #1;

    // zero beat length is rejected
    start_job(0, 3, 32'hA, 32'hB);
    check_val("cfg_status", {60'd0, status}, 64'd8);
    for (int k = 0; k < 4; k++) begin
      check_val("cfg_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    check_val("cfg_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;

    // reset in the middle of a job with a buffered beat
    run_job(4, 3, 3, -1, 32'hA, 32'hB);
    m_tready = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check_val("mrst_mvalid", {63'd0, m_tvalid}, 64'd0);
    check_val("mrst_mdata", m_tdata, 64'd0);
    check_val("mrst_mlast", {63'd0, m_tlast}, 64'd0);
    check_val("mrst_muser", {32'd0, m_tuser}, 64'd0);
    check_val("mrst_sready", {63'd0, s_tready}, 64'd0);
    check_val("mrst_busy", {63'd0, busy}, 64'd0);
    check_val("mrst_cnt", {48'd0, pkt_count}, 64'd0);
    check_val("mrst_status", {60'd0, status}, 64'd0);
    rstn = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
